main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 No parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 op  input  7  opcode field from the instruction register (stable from DECODE until FETCH).
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 ALUOp  output  2  to ALU_Decoder: 00 add, 01 subtract/compare, 10 decode funct3/funct7.
REQ-007 ALUSrcA  output  2  00 PC, 01 OldPC, 10 register A.
REQ-008 ALUSrcB  output  2  00 register B, 01 ImmExt, 10 constant 4.
REQ-009 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-010 AdrSrc  output  1  0 PC, 1 Result.
REQ-011 IRWrite, RegWrite, MemWrite, PCWrite  output  1 each  write enables.
REQ-012 Illegal  output  1  one-cycle flag for an unsupported opcode.
REQ-013 State  output  4  current state code, for debug.

Function
REQ-014 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
REQ-015 State register updates on rising clk; every output is a Moore function of state, except PCWrite (REQ-018) and Illegal (REQ-019).
REQ-016 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR for op 0000011 (lw) or 0100011 (sw); EXECR for 0110011; EXECI for 0010011; JAL for 1101111; BEQ for 1100011; FETCH for any other op.
- MEMADR->MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD->MEMWB; MEMWB->FETCH; MEMWRITE->FETCH.
- EXECR, EXECI and JAL ->ALUWB.
- ALUWB->FETCH; BEQ->FETCH.
- Codes 11-15 ->FETCH.
REQ-017 Outputs per state (unlisted outputs are 0):
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-018 PCUpdate and Branch are internal signals; PCWrite = PCUpdate | (Branch & Zero), combinational, so Zero reaches PCWrite in the same cycle.
REQ-019 Illegal=1 only while in DECODE with an op not listed in REQ-016; FETCH follows on the next edge.
REQ-020 Per-instruction cycle counts, FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
REQ-021 A change of op outside DECODE and MEMADR has no effect.

Reset
REQ-022 While reset=1: State=0 and all outputs take FETCH values asynchronously, without waiting for clk.
REQ-023 Reset asserted in any state aborts the instruction; no RegWrite or MemWrite pulse occurs after reset asserts.
REQ-024 After reset releases, the first rising clk moves the FSM to DECODE.

Verification
REQ-025 Reset asserted mid-MEMREAD, between edges -> State=0, IRWrite=1 and PCWrite=1 before the next edge.
REQ-026 op=0000011 -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-027 op=0110011 -> sequence 0,1,6,8,0; ALUOp=10 in state 6; RegWrite=1 in state 8.
REQ-028 op=1100011: Zero=1 in BEQ -> PCWrite=1 and ALUOp=01; Zero=0 -> PCWrite=0; sequence 0,1,9,0.
REQ-029 op=0100011 -> sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5.
REQ-030 op=0000000 -> Illegal=1 only in DECODE, then State=0; op=1101111 -> sequence 0,1,10,8,0, with PCWrite=1 in state 10.

Source files
------------

// File: rtl/main_fsm_if.sv
// main_fsm_if -- control bundle between the multicycle control FSM and its datapath.
//   op, Zero                      : datapath -> FSM (opcode field, ALU zero flag)
//   ALUOp, ALUSrcA, ALUSrcB,
//   ResultSrc, AdrSrc             : FSM -> datapath mux/ALU selects
//   IRWrite, RegWrite, MemWrite,
//   PCWrite                       : FSM -> datapath write enables
//   Illegal                       : FSM -> one-cycle unsupported-opcode flag
//   State                         : FSM -> current state code (debug)
// modport master is the FSM side, modport slave is the datapath side.
interface main_fsm_if;
    logic [6:0] op;
    logic       Zero;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op, Zero,
        output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
               IRWrite, RegWrite, MemWrite, PCWrite, Illegal, State
    );

    modport slave (
        output op, Zero,
        input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
               IRWrite, RegWrite, MemWrite, PCWrite, Illegal, State
    );
endinterface

// File: rtl/main_fsm.sv
// main_fsm -- multicycle RISC-V control state machine.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces FETCH immediately
//   bus   : main_fsm_if.master (op/Zero in, datapath controls and State out)
// All controls are Moore functions of the state, except PCWrite (which folds
// in Zero combinationally for branches) and Illegal (which looks at op in DECODE).
module main_fsm (
    input  logic          clk,
    input  logic          reset,
    main_fsm_if.master    bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t state_q;
    state_t state_d;
    logic   illegal_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused codes 11-15 fall into the default and recover to FETCH.
    always_comb begin
        state_d    = FETCH;
        illegal_op = 1'b0;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode. Because state_q is forced to FETCH asynchronously, the
    // outputs take FETCH values as soon as reset rises.
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       pc_update;
    logic       branch;

    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ALUOp     = alu_op;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.AdrSrc    = adr_src;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.MemWrite  = mem_write;
    // Zero feeds PCWrite without a register so a taken branch updates PC this cycle.
    assign bus.PCWrite   = pc_update | (branch & bus.Zero);
    assign bus.Illegal   = illegal_op;
    assign bus.State     = state_q;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm -- self-checking bench for main_fsm: directed vector table,
// hand-written reset/branch corner cases, and randomized instruction streams
// compared against a per-instruction state-sequence model.
module tb_main_fsm;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    main_fsm_if bus_if ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, Illegal}
    logic [13:0] act_ctrl;
    assign act_ctrl = {bus_if.ALUOp, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ResultSrc,
                       bus_if.AdrSrc, bus_if.IRWrite, bus_if.RegWrite, bus_if.MemWrite,
                       bus_if.PCWrite, bus_if.Illegal};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       zero;
        int         len;
        int         seq[6];
    } vec_t;

    vec_t vecs[9];
    int   ref_seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    // Expected control word for a state code, straight from the per-state output table.
    function automatic logic [13:0] exp_ctrl(input int s, input logic [6:0] o, input logic z);
        logic [1:0] aluop, srca, srcb, res;
        logic adr, irw, rw, mw, pcw, ill;
        aluop = 0; srca = 0; srcb = 0; res = 0;
        adr = 0; irw = 0; rw = 0; mw = 0; pcw = 0; ill = 0;
        case (s)
            0:  begin irw = 1; srcb = 2'b10; res = 2'b10; pcw = 1; end
            1:  begin srca = 2'b01; srcb = 2'b01; ill = !is_legal(o); end
            2:  begin srca = 2'b10; srcb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin srca = 2'b10; aluop = 2'b10; end
            7:  begin srca = 2'b10; srcb = 2'b01; aluop = 2'b10; end
            8:  rw = 1;
            9:  begin srca = 2'b10; aluop = 2'b01; pcw = z; end
            10: begin srca = 2'b01; srcb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {aluop, srca, srcb, res, adr, irw, rw, mw, pcw, ill};
    endfunction

    // Reference model: the state path an instruction takes, FETCH through its last state.
    function automatic void build_seq(input logic [6:0] o);
        ref_seq = {0, 1};
        case (o)
            7'b0000011: ref_seq = {ref_seq, 2, 3, 4};
            7'b0100011: ref_seq = {ref_seq, 2, 5};
            7'b0110011: ref_seq = {ref_seq, 6, 8};
            7'b0010011: ref_seq = {ref_seq, 7, 8};
            7'b1101111: ref_seq = {ref_seq, 10, 8};
            7'b1100011: ref_seq = {ref_seq, 9};
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from FETCH. abort_at >= 0 asserts reset mid-cycle at that step.
    task automatic run_instr(input string tag, input logic [6:0] o, input int seq[6],
                             input int len, input bit rnd, input logic zf, input int abort_at);
        logic z;
        bus_if.op = o;
        for (int i = 0; i < len; i++) begin
            z = rnd ? 1'($urandom_range(0, 1)) : zf;
            bus_if.Zero = z;
            // op may wander outside DECODE/MEMADR without effect
            if (rnd && seq[i] > 2) bus_if.op = 7'($urandom);
            #1;
            chk({tag, " state"}, 32'(bus_if.State), 32'(seq[i]));
            chk({tag, " ctrl"}, 32'(act_ctrl), 32'(exp_ctrl(seq[i], o, z)));
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk({tag, " rst state"}, 32'(bus_if.State), 32'd0);
                chk({tag, " rst ctrl"}, 32'(act_ctrl), 32'(exp_ctrl(0, o, z)));
                tick();
                chk({tag, " rst hold"}, 32'(bus_if.State), 32'd0);
                chk({tag, " rst hold ctrl"}, 32'(act_ctrl), 32'(exp_ctrl(0, o, bus_if.Zero)));
                reset = 1'b0;
                return;
            end
            tick();
        end
    endtask

    task automatic add_vec(input int idx, input string name, input logic [6:0] op,
                           input logic zero, input int len,
                           input int s0, input int s1, input int s2,
                           input int s3, input int s4, input int s5);
        vecs[idx].name = name;
        vecs[idx].op   = op;
        vecs[idx].zero = zero;
        vecs[idx].len  = len;
        vecs[idx].seq  = '{s0, s1, s2, s3, s4, s5};
    endtask

    initial begin
        int         seq[6];
        logic [6:0] o;
        int         abort;

        add_vec(0, "lw",     7'b0000011, 1'b0, 5, 0, 1, 2, 3, 4, 0);
        add_vec(1, "sw",     7'b0100011, 1'b1, 4, 0, 1, 2, 5, 0, 0);
        add_vec(2, "rtype",  7'b0110011, 1'b1, 4, 0, 1, 6, 8, 0, 0);
        add_vec(3, "itype",  7'b0010011, 1'b0, 4, 0, 1, 7, 8, 0, 0);
        add_vec(4, "jal",    7'b1101111, 1'b0, 4, 0, 1, 10, 8, 0, 0);
        add_vec(5, "beq_t",  7'b1100011, 1'b1, 3, 0, 1, 9, 0, 0, 0);
        add_vec(6, "beq_nt", 7'b1100011, 1'b0, 3, 0, 1, 9, 0, 0, 0);
        add_vec(7, "ill0",   7'b0000000, 1'b1, 2, 0, 1, 0, 0, 0, 0);
        add_vec(8, "ill7f",  7'b1111111, 1'b0, 2, 0, 1, 0, 0, 0, 0);

        // Reset acts without a clock edge.
        reset = 1'b0;
        bus_if.op = 7'b0000000;
        bus_if.Zero = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async reset state", 32'(bus_if.State), 32'd0);
        chk("async reset ctrl", 32'(act_ctrl), 32'(exp_ctrl(0, 7'd0, 1'b0)));
        tick();
        chk("reset held state", 32'(bus_if.State), 32'd0);
        reset = 1'b0;
        tick();
        chk("first edge decode", 32'(bus_if.State), 32'd1);
        tick();
        chk("illegal back to fetch", 32'(bus_if.State), 32'd0);

        // Directed vector table.
        for (int v = 0; v < 9; v++) begin
            run_instr(vecs[v].name, vecs[v].op, vecs[v].seq, vecs[v].len, 1'b0, vecs[v].zero, -1);
        end

        // Reset mid-MEMREAD between edges.
        run_instr("lw_abort", 7'b0000011, '{0, 1, 2, 3, 4, 0}, 5, 1'b0, 1'b0, 3);
        tick();
        chk("after abort decode", 32'(bus_if.State), 32'd1);
        bus_if.op = 7'b0110011;
        tick();
        chk("after abort exec", 32'(bus_if.State), 32'd6);
        tick();
        tick();
        chk("after abort fetch", 32'(bus_if.State), 32'd0);

        // Zero reaches PCWrite inside the BEQ cycle.
        bus_if.op = 7'b1100011;
        bus_if.Zero = 1'b0;
        tick();
        tick();
        chk("beq state", 32'(bus_if.State), 32'd9);
        bus_if.Zero = 1'b0;
        #1 chk("beq pcwrite z0", 32'(bus_if.PCWrite), 32'd0);
        bus_if.Zero = 1'b1;
        #1 chk("beq pcwrite z1", 32'(bus_if.PCWrite), 32'd1);
        chk("beq aluop", 32'(bus_if.ALUOp), 32'd1);
        bus_if.Zero = 1'b0;
        #1 chk("beq pcwrite z0 again", 32'(bus_if.PCWrite), 32'd0);
        tick();
        chk("beq to fetch", 32'(bus_if.State), 32'd0);

        // Randomized instruction stream against the sequence model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1101111;
                5: o = 7'b1100011;
                6: o = 7'b0000000;
                default: o = 7'($urandom);
            endcase
            build_seq(o);
            seq = '{0, 0, 0, 0, 0, 0};
            for (int k = 0; k < ref_seq.size(); k++) seq[k] = ref_seq[k];
            abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ref_seq.size() - 1)) : -1;
            run_instr($sformatf("rnd%0d", n), o, seq, ref_seq.size(), 1'b1, 1'b0, abort);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
